// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types for the multi-channel clock divider
package clk_div_pkg;

    localparam int DIV_W_MAX = 32;

    typedef enum logic {
        DIV_TOGGLE = 1'b0,
        DIV_STROBE = 1'b1
    } div_mode_e;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN_LOW  = 2'd1,
        RUN_HIGH = 2'd2
    } ch_state_e;

    typedef struct packed {
        logic [DIV_W_MAX-1:0] div;
        logic [DIV_W_MAX-1:0] high;
        div_mode_e            mode;
    } div_cfg_t;

    function automatic div_cfg_t make_cfg(
        input logic [DIV_W_MAX-1:0] div,
        input logic [DIV_W_MAX-1:0] high,
        input div_mode_e            mode
    );
        div_cfg_t c;
        c.div  = div;
        c.high = high;
        c.mode = mode;
        return c;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// rtl/clk_div_channel.sv - one divider channel: counter, phase FSM, shadowed config
// Counter widths up to DIV_W_MAX bits; the config struct carries the full width.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int               CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = '0
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     en,
    input  logic     wr_en,
    input  div_cfg_t wr_cfg,
    output logic     pending,
    output logic     slow_clk,
    output logic     tick
);

    localparam div_cfg_t RESET_CFG = make_cfg(DIV_W_MAX'(DEFAULT_DIV),
                                              DIV_W_MAX'(DEFAULT_DIV),
                                              DIV_TOGGLE);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             slow_q, slow_d;
    logic             tick_q, tick_d;
    div_cfg_t         act_q, act_d;
    div_cfg_t         sh_q, sh_d;
    logic             pend_q, pend_d;

    logic [CNT_W-1:0] limit;
    logic             terminal;
    logic             mode_change;

    always_comb begin
        limit       = (state_q == RUN_HIGH) ? act_q.high[CNT_W-1:0] : act_q.div[CNT_W-1:0];
        terminal    = (state_q != DISABLED) && (cnt_q == limit);
        mode_change = pend_q && (sh_q.mode != act_q.mode);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slow_d  = slow_q;
        tick_d  = 1'b0;
        act_d   = act_q;
        sh_d    = sh_q;
        pend_d  = pend_q;

        if (!en) begin
            // A pending write is committed as the channel stops rather than lost.
            state_d = DISABLED;
            cnt_d   = '0;
            slow_d  = 1'b0;
            if (pend_q) begin
                act_d  = sh_q;
                pend_d = 1'b0;
            end
        end else if (state_q == DISABLED) begin
            state_d = RUN_LOW;
            cnt_d   = '0;
            slow_d  = 1'b0;
        end else if (terminal) begin
            cnt_d = '0;
            if (pend_q) begin
                act_d  = sh_q;
                pend_d = 1'b0;
            end
            if (mode_change) begin
                state_d = RUN_LOW;
                slow_d  = 1'b0;
            end else if (act_q.mode == DIV_STROBE) begin
                state_d = RUN_LOW;
                slow_d  = 1'b0;
                tick_d  = 1'b1;
            end else if (state_q == RUN_LOW) begin
                state_d = RUN_HIGH;
                slow_d  = 1'b1;
                tick_d  = 1'b1;
            end else begin
                state_d = RUN_LOW;
                slow_d  = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Writes land directly unless the channel keeps running past this cycle.
        if (wr_en) begin
            if ((state_q == DISABLED) || !en) begin
                act_d  = wr_cfg;
                pend_d = 1'b0;
            end else begin
                sh_d   = wr_cfg;
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DISABLED;
            cnt_q   <= '0;
            slow_q  <= 1'b0;
            tick_q  <= 1'b0;
            act_q   <= RESET_CFG;
            sh_q    <= RESET_CFG;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slow_q  <= slow_d;
            tick_q  <= tick_d;
            act_q   <= act_d;
            sh_q    <= sh_d;
            pend_q  <= pend_d;
        end
    end

    assign pending  = pend_q;
    assign slow_clk = slow_q;
    assign tick     = tick_q;

endmodule

// File: rtl/clk_divider_multi.sv
// rtl/clk_divider_multi.sv - NUM_CH programmable clock dividers behind one config port
// Define CLKDIV_DUTY_EN to add cfg_high (independent high-phase length); otherwise 50% duty.
module clk_divider_multi
    import clk_div_pkg::*;
#(
    parameter int               NUM_CH      = 4,
    parameter int               CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = '0
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_CH-1:0]                           en,
    input  logic                                        cfg_valid,
    output logic                                        cfg_ready,
    input  logic [$clog2((NUM_CH > 1) ? NUM_CH : 2)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                            cfg_div,
    input  div_mode_e                                   cfg_mode,
`ifdef CLKDIV_DUTY_EN
    input  logic [CNT_W-1:0]                            cfg_high,
`endif
    output logic [NUM_CH-1:0]                           slow_clk,
    output logic [NUM_CH-1:0]                           tick
);

    localparam int CH_W = $clog2((NUM_CH > 1) ? NUM_CH : 2);

    logic [NUM_CH-1:0] pending;
    logic [CNT_W-1:0]  high_src;
    div_cfg_t          cfg_word;
    logic              accept;

`ifdef CLKDIV_DUTY_EN
    assign high_src = cfg_high;
`else
    assign high_src = cfg_div;
`endif

    always_comb begin
        cfg_word = make_cfg(DIV_W_MAX'(cfg_div), DIV_W_MAX'(high_src), cfg_mode);
    end

    // Out-of-range channel numbers read as ready and the write is dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending[i];
            end
        end
    end

    assign accept = cfg_valid && cfg_ready;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en       (en[gi]),
            .wr_en    (accept && (cfg_ch == CH_W'(gi))),
            .wr_cfg   (cfg_word),
            .pending  (pending[gi]),
            .slow_clk (slow_clk[gi]),
            .tick     (tick[gi])
        );
    end

endmodule
